// File: rtl/readout_pkg.sv
// Shared types and default timing for the pixel readout path.
// Used by the scheduler and the pixel array top.
package readout_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    GATE,
    EMIT
  } state_e;

  localparam int DEF_GATE_CYCLES   = 50000;
  localparam int DEF_SETTLE_CYCLES = 4;

endpackage

// File: rtl/edge_gate_counter.sv
// Edge detector with saturating counter for one gated measurement.
// READOUT_BOTH_EDGES_EN counts both edges instead of rising only.
module edge_gate_counter #(
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample,
  input  logic                  clr,
  input  logic                  en,
  output logic [COUNT_BITS-1:0] count_d,
  output logic [COUNT_BITS-1:0] count_q
);

  logic prev_q;
  logic prev_d;
  logic edge_hit;

`ifdef READOUT_BOTH_EDGES_EN
  assign edge_hit = sample ^ prev_q;
`else
  assign edge_hit = sample & ~prev_q;
`endif

  always_comb begin
    prev_d  = sample;
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && edge_hit && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      count_q <= '0;
    end else begin
      prev_q  <= prev_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pixel_readout_scheduler.sv
// Scans frequency-coded pixels: select, settle, gate-count, emit.
// Optional READOUT_BOTH_EDGES_EN is handled in edge_gate_counter.
module pixel_readout_scheduler
  import readout_pkg::*;
#(
  parameter  int NUM_PIXELS    = 16,
  parameter  int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter  int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter  int COUNT_BITS    = 16,
  localparam int SEL_BITS      = $clog2(NUM_PIXELS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  CONTINUOUS,
  input  logic [NUM_PIXELS-1:0] PIX_FREQ_IN,
  output logic [SEL_BITS-1:0]   PIX_SEL,
  output logic                  BUSY,
  output logic [COUNT_BITS-1:0] DATA_OUT,
  output logic [SEL_BITS-1:0]   DATA_PIX,
  output logic                  DATA_VALID,
  input  logic                  DATA_READY,
  output logic                  FRAME_DONE
);

  localparam int TMAX     = (GATE_CYCLES > SETTLE_CYCLES) ?
                            GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_BITS = $clog2(TMAX + 1);

  localparam logic [TMR_BITS-1:0] GATE_END   = TMR_BITS'(GATE_CYCLES - 1);
  localparam logic [TMR_BITS-1:0] SETTLE_END = TMR_BITS'(SETTLE_CYCLES - 1);
  localparam logic [SEL_BITS-1:0] LAST_PIX   = SEL_BITS'(NUM_PIXELS - 1);

  state_e                state_q, state_d;
  logic [TMR_BITS-1:0]   tmr_q, tmr_d;
  logic [SEL_BITS-1:0]   pix_sel_q, pix_sel_d;
  logic [COUNT_BITS-1:0] data_out_q, data_out_d;
  logic [SEL_BITS-1:0]   data_pix_q, data_pix_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  busy_q, busy_d;

  logic [COUNT_BITS-1:0] cnt_d;
  logic [COUNT_BITS-1:0] cnt_q;

  edge_gate_counter #(
    .COUNT_BITS (COUNT_BITS)
  ) u_cnt (
    .clk     (CLK),
    .rst     (RST),
    .sample  (PIX_FREQ_IN[pix_sel_q]),
    .clr     (state_q == SETTLE),
    .en      (state_q == GATE),
    .count_d (cnt_d),
    .count_q (cnt_q)
  );

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    pix_sel_d    = pix_sel_q;
    data_out_d   = data_out_q;
    data_pix_d   = data_pix_q;
    data_valid_d = data_valid_q;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = SETTLE;
          tmr_d     = '0;
          pix_sel_d = '0;
          busy_d    = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_q == SETTLE_END) begin
          state_d = GATE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      GATE: begin
        // cnt_d includes an edge seen in the final gate cycle
        if (tmr_q == GATE_END) begin
          state_d      = EMIT;
          tmr_d        = '0;
          data_out_d   = cnt_d;
          data_pix_d   = pix_sel_q;
          data_valid_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      EMIT: begin
        if (DATA_READY) begin
          data_valid_d = 1'b0;
          tmr_d        = '0;
          if (pix_sel_q == LAST_PIX) begin
            frame_done_d = 1'b1;
            pix_sel_d    = '0;
            if (CONTINUOUS) begin
              state_d = SETTLE;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            pix_sel_d = pix_sel_q + 1'b1;
            state_d   = SETTLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      pix_sel_q    <= '0;
      data_out_q   <= '0;
      data_pix_q   <= '0;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      pix_sel_q    <= pix_sel_d;
      data_out_q   <= data_out_d;
      data_pix_q   <= data_pix_d;
      data_valid_q <= data_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign PIX_SEL    = pix_sel_q;
  assign BUSY       = busy_q;
  assign DATA_OUT   = data_out_q;
  assign DATA_PIX   = data_pix_q;
  assign DATA_VALID = data_valid_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_pixel_readout_scheduler.sv
// Bench for pixel_readout_scheduler against a time-based waveform model.
// A second small-width instance exercises count saturation.
module tb_pixel_readout_scheduler;

  localparam int N  = 4;
  localparam int G  = 100;
  localparam int S  = 4;
  localparam int CB = 8;
  localparam int SB = 2;
`ifdef READOUT_BOTH_EDGES_EN
  localparam bit BOTH = 1'b1;
`else
  localparam bit BOTH = 1'b0;
`endif
  localparam int E = BOTH ? 2 : 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cont;
  logic          ready;
  logic [N-1:0]  pix;
  logic [SB-1:0] pix_sel;
  logic          busy;
  logic [CB-1:0] data_out;
  logic [SB-1:0] data_pix;
  logic          valid;
  logic          fd;

  logic          s_start;
  logic          s_cont;
  logic          s_ready;
  logic [N-1:0]  s_pix;
  logic [SB-1:0] s_sel;
  logic          s_busy;
  logic [4:0]    s_out;
  logic [SB-1:0] s_dpix;
  logic          s_valid;
  logic          s_fd;

  always #5 clk = ~clk;

  pixel_readout_scheduler #(
    .NUM_PIXELS(N), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .COUNT_BITS(CB)
  ) dut (
    .CLK(clk), .RST(rst), .START(start), .CONTINUOUS(cont),
    .PIX_FREQ_IN(pix), .PIX_SEL(pix_sel), .BUSY(busy),
    .DATA_OUT(data_out), .DATA_PIX(data_pix), .DATA_VALID(valid),
    .DATA_READY(ready), .FRAME_DONE(fd)
  );

  pixel_readout_scheduler #(
    .NUM_PIXELS(N), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .COUNT_BITS(5)
  ) dut_sat (
    .CLK(clk), .RST(rst), .START(s_start), .CONTINUOUS(s_cont),
    .PIX_FREQ_IN(s_pix), .PIX_SEL(s_sel), .BUSY(s_busy),
    .DATA_OUT(s_out), .DATA_PIX(s_dpix), .DATA_VALID(s_valid),
    .DATA_READY(s_ready), .FRAME_DONE(s_fd)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int half[N];
  int ph[N];
  bit cst[N];

  bit m_busy = 0;
  int m_pix  = 0;
  int m_vcyc = 0;
  int fd_exp = -1;
  int fd_seen = -1;
  int fd_count = 0;
  int s_vcyc = -1;
  int start_cyc = 0;
  int first_valid = -1;
  int len1;
  int res[$];
  bit ab;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit val(input int p, input int t);
    if (half[p] == 0) return cst[p];
    return bit'(((t + ph[p]) / half[p]) % 2);
  endfunction

  function automatic bit sval(input int t);
    return bit'(t % 2);
  endfunction

  // Edges seen in the G cycles that precede the result appearing at v
  function automatic int model_cnt(input int p, input int v, input bit sat);
    int n;
    int mx;
    bit a;
    bit b;
    n = 0;
    for (int t = v - G; t < v; t++) begin
      a = sat ? sval(t) : val(p, t);
      b = sat ? sval(t - 1) : val(p, t - 1);
      if (BOTH ? (a != b) : (a && !b)) n++;
    end
    mx = sat ? 31 : (1 << CB) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < N; p++) pix[p] = val(p, cyc);
    s_pix = '0;
    s_pix[0] = sval(cyc);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix_sel"}, int'(pix_sel), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_data_out"}, int'(data_out), 0);
    chk({tag, "_data_pix"}, int'(data_pix), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_frame_done"}, int'(fd), 0);
    chk({tag, "_sat_idle"},
        int'({s_sel, s_busy, s_out, s_dpix, s_valid, s_fd}), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    start_cyc = cyc;
    first_valid = -1;
    m_busy = 1'b1;
    m_pix = 0;
    m_vcyc = cyc + 1 + S + G;
  endtask

  task automatic run(input int n_frames, input int stall_pix,
                     input int stall_len, input bit rnd,
                     input int abort_pix, output bit aborted);
    int frames;
    int lim;
    frames = 0;
    lim = 0;
    aborted = 1'b0;
    res.delete();
    fd_count = 0;
    forever begin
      tick();
      lim++;
      chk("busy", int'(busy), int'(m_busy));
      chk("frame_done", int'(fd), int'(cyc == fd_exp));
      chk("pix_sel", int'(pix_sel), m_pix);
      chk("data_valid", int'(valid), int'(m_busy && cyc >= m_vcyc));
      if (cyc == s_vcyc) begin
        chk("sat_valid", int'(s_valid), 1);
        chk("sat_model", int'(s_out), model_cnt(0, s_vcyc, 1'b1));
        chk("sat_count", int'(s_out), 31);
      end
      if (fd) begin
        fd_count++;
        fd_seen = cyc;
      end
      if (valid && first_valid < 0) first_valid = cyc;
      if (!m_busy || lim > 6000) break;
      if (abort_pix == m_pix && cyc == m_vcyc - G / 2) begin
        aborted = 1'b1;
        break;
      end
      ready = rnd ? ($urandom % 4 != 0) : 1'b1;
      cont = rnd ? 1'($urandom % 2) : 1'b0;
      if (cyc >= m_vcyc) begin
        chk("data_pix", int'(data_pix), m_pix);
        chk("data_out", int'(data_out), model_cnt(m_pix, m_vcyc, 1'b0));
        if (m_pix == stall_pix && cyc < m_vcyc + stall_len) ready = 1'b0;
        if (ready) begin
          res.push_back(int'(data_out));
          if (m_pix == N - 1) begin
            frames++;
            cont = (frames < n_frames);
            fd_exp = cyc + 1;
            m_pix = 0;
            if (cont) m_vcyc = cyc + 1 + S + G;
            else m_busy = 1'b0;
          end else begin
            m_pix++;
            m_vcyc = cyc + 1 + S + G;
          end
        end
      end
      start = rnd ? ($urandom % 3 == 0) : 1'b0;
      s_start = 1'b0;
    end
    start = 1'b0;
    ready = 1'b1;
    cont = 1'b0;
    chk("no_timeout", int'(lim > 6000), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cont = 1'b0;
    ready = 1'b1;
    pix = '0;
    s_start = 1'b0;
    s_cont = 1'b0;
    s_ready = 1'b1;
    s_pix = '0;
    half = '{5, 10, 25, 50};
    ph = '{0, 0, 0, 0};
    cst = '{0, 0, 0, 0};
    repeat (3) tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();

    // Nominal frame plus saturation instance
    do_start();
    s_start = 1'b1;
    s_vcyc = cyc + 1 + S + G;
    run(1, -1, 0, 1'b0, -1, ab);
    chk("t1_results", res.size(), 4);
    chk("t1_pix0", res.size() > 0 ? res[0] : -1, 10 * E);
    chk("t1_pix1", res.size() > 1 ? res[1] : -1, 5 * E);
    chk("t1_pix2", res.size() > 2 ? res[2] : -1, 2 * E);
    chk("t1_pix3", res.size() > 3 ? res[3] : -1, 1 * E);
    chk("t1_frame_done_cnt", fd_count, 1);
    chk("t1_first_valid", first_valid - start_cyc, 1 + S + G);
    len1 = fd_seen - start_cyc;
    chk("t1_frame_len", len1, N * (S + G + 1) + 1);
    repeat (3) tick();

    // Backpressure on pixel 1
    do_start();
    run(1, 1, 30, 1'b0, -1, ab);
    chk("t2_frame_len", fd_seen - start_cyc, len1 + 30);
    chk("t2_pix1", res.size() > 1 ? res[1] : -1, 5 * E);
    chk("t2_pix2", res.size() > 2 ? res[2] : -1, 2 * E);
    repeat (3) tick();

    // Constant-high pixel selected after a constant-low one
    half = '{0, 0, 7, 3};
    cst = '{0, 1, 0, 0};
    do_start();
    run(1, -1, 0, 1'b0, -1, ab);
    chk("t3_pix0", res.size() > 0 ? res[0] : -1, 0);
    chk("t3_pix1", res.size() > 1 ? res[1] : -1, 0);
    repeat (3) tick();

    // Random rates, random ready/START/CONTINUOUS, three chained frames
    for (int p = 0; p < N; p++) begin
      half[p] = $urandom_range(1, 30);
      ph[p] = $urandom_range(0, 59);
    end
    do_start();
    run(3, -1, 0, 1'b1, -1, ab);
    chk("t4_frames", fd_count, 3);
    chk("t4_results", res.size(), 3 * N);
    repeat (3) tick();

    // Reset in the middle of pixel 2's gate window
    half = '{5, 10, 25, 50};
    ph = '{0, 0, 0, 0};
    do_start();
    run(1, -1, 0, 1'b0, 2, ab);
    chk("t5_aborted", int'(ab), 1);
    rst = 1'b1;
    tick();
    chk_zero("t5_mid_reset");
    rst = 1'b0;
    m_busy = 1'b0;
    m_pix = 0;
    tick();
    chk("t5_stay_idle", int'(busy), 0);
    do_start();
    run(1, -1, 0, 1'b0, -1, ab);
    chk("t5_results", res.size(), 4);
    chk("t5_pix0", res.size() > 0 ? res[0] : -1, 10 * E);
    chk("t5_pix3", res.size() > 3 ? res[3] : -1, 1 * E);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
